// File: rtl/vec4_bist_pkg.sv
// Shared types and constants for the vec4_bist exhaustive tester of 4-bit
// two-operand gate DUTs.
package vec4_bist_pkg;

  localparam int VEC_COUNT = 256;
  localparam int VEC_W     = 8;
  localparam int OPND_W    = 4;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef logic [VEC_W-1:0] vec_idx_t;

  function automatic logic is_last_vec(input vec_idx_t idx);
    return idx == vec_idx_t'(VEC_COUNT - 1);
  endfunction

endpackage

// File: rtl/vec4_ref_model.sv
// Golden model for the gate under test: expected y for operands a/b.
// Swap this module to retarget the tester at another 4-bit gate.
module vec4_ref_model
  import vec4_bist_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [OPND_W-1:0] y_exp
);

  always_comb begin
    y_exp = a & b;
  end

endmodule

// File: rtl/vec4_bist.sv
// Exhaustive 256-vector BIST for a 4-bit AND DUT with settle delay per vector.
// Optional macro VEC4_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module vec4_bist
  import vec4_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [3:0]        a,
  output logic [3:0]        b,
  input  logic [3:0]        y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [3:0]        fail_a,
  output logic [3:0]        fail_b
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t              state_q, state_d;
  vec_idx_t            idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [OPND_W-1:0]   fail_a_q, fail_a_d;
  logic [OPND_W-1:0]   fail_b_q, fail_b_d;
  logic [OPND_W-1:0]   y_exp;
  logic                start_ok;
  logic                mismatch;
  logic                stop_on_fail;

  assign a = idx_q[VEC_W-1:OPND_W];
  assign b = idx_q[OPND_W-1:0];

  vec4_ref_model u_ref_model (
    .a     (a),
    .b     (b),
    .y_exp (y_exp)
  );

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = (state_q == ST_CHECK) && (y != y_exp);

`ifdef VEC4_BIST_STOP_ON_FAIL_EN
  assign stop_on_fail = mismatch;
`else
  assign stop_on_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_APPLY;
      ST_APPLY:         state_d = ST_SETTLE;
      ST_SETTLE:        if (cnt_q == '0) state_d = ST_CHECK;
      ST_CHECK: begin
        if (is_last_vec(idx_q) || stop_on_fail) state_d = ST_DONE;
        else                                    state_d = ST_APPLY;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  // Countdown is loaded while in APPLY so it is ready on the first SETTLE cycle.
  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    if (start_ok) begin
      idx_d    = '0;
      cnt_d    = '0;
      err_d    = '0;
      fail_a_d = '0;
      fail_b_d = '0;
    end else begin
      case (state_q)
        ST_APPLY:  cnt_d = SETTLE_LOAD;
        ST_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              fail_a_d = a;
              fail_b_d = b;
            end
          end
          if (!is_last_vec(idx_q) && !stop_on_fail) idx_d = idx_q + VEC_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_APPLY, ST_SETTLE, ST_CHECK: busy = 1'b1;
      ST_DONE:                       done = 1'b1;
      default: ;
    endcase
  end

  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_vec4_bist.sv
// Self-checking bench for vec4_bist: the bench plays the gate DUT with a
// randomizable per-vector fault table and predicts sweep results from it.
module tb_vec4_bist;

  localparam int SETTLE       = 2;
  localparam int ERR_W        = 9;
  localparam int PER_VEC      = SETTLE + 2;
  localparam int SWEEP_CYCLES = 256 * PER_VEC;
  localparam int TIMEOUT      = SWEEP_CYCLES + 200;

`ifdef VEC4_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       a, b, y, fail_a, fail_b;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;

  logic [3:0] flip_tbl [256];

  int n_vectors     = 0;
  int n_miscompares = 0;

  int exp_err, exp_first, exp_latency;

  int pt_idx [4] = '{8'h00, 8'hA5, 8'hFF, 8'hCA};
  int pt_a   [4] = '{4'b0000, 4'b1010, 4'b1111, 4'b1100};
  int pt_b   [4] = '{4'b0000, 4'b0101, 4'b1111, 4'b1010};
  int pt_y   [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b1000};

  always #5 clk = ~clk;

  // Behaves as the gate under test: correct AND, corrupted where the table says.
  assign y = (a & b) ^ flip_tbl[{a, b}];

  vec4_bist #(
    .SETTLE_CYCLES (SETTLE),
    .ERR_W         (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_a"},      32'(a), 0);
    checkOutput({tag, "_b"},      32'(b), 0);
    checkOutput({tag, "_busy"},   32'(busy), 0);
    checkOutput({tag, "_done"},   32'(done), 0);
    checkOutput({tag, "_pass"},   32'(pass), 0);
    checkOutput({tag, "_err"},    32'(err_count), 0);
    checkOutput({tag, "_fail_a"}, 32'(fail_a), 0);
    checkOutput({tag, "_fail_b"}, 32'(fail_b), 0);
  endtask

  // Walks all 256 operand pairs in order and counts observed bad results.
  task automatic modelSweep();
    exp_err   = 0;
    exp_first = -1;
    for (int v = 0; v < 256; v++) begin
      int av   = v / 16;
      int bv   = v % 16;
      int good = av & bv;
      int seen = good ^ int'(flip_tbl[v]);
      if (seen != good) begin
        if (exp_first < 0) exp_first = v;
        exp_err++;
        if (STOP_EN) break;
      end
    end
    if (STOP_EN && exp_first >= 0) exp_latency = (exp_first + 1) * PER_VEC;
    else                           exp_latency = SWEEP_CYCLES;
  endtask

  task automatic runSweep(input string tag, input int busy_start_at, input int reset_at);
    int cyc = 0;
    modelSweep();
    applyStimulus();
    checkOutput({tag, "_busy_start"}, 32'(busy), 1);
    checkOutput({tag, "_done_cleared"}, 32'(done), 0);
    while (cyc < TIMEOUT && !done) begin
      int k = cyc / PER_VEC;
      int p = cyc % PER_VEC;
      if (cyc == reset_at) begin
        checkOutput({tag, "_a_before_rst"}, 32'(a), 32'(k / 16));
        rst_n = 1'b0;
        #1;
        checkResetState({tag, "_midrst"});
        return;
      end
      if (p == PER_VEC - 1) begin
        for (int i = 0; i < 4; i++) begin
          if (k == pt_idx[i]) begin
            checkOutput($sformatf("%s_pt%0d_a", tag, i), 32'(a), 32'(pt_a[i]));
            checkOutput($sformatf("%s_pt%0d_b", tag, i), 32'(b), 32'(pt_b[i]));
            if (flip_tbl[k] == 4'd0)
              checkOutput($sformatf("%s_pt%0d_y", tag, i), 32'(y), 32'(pt_y[i]));
          end
        end
      end
      if (cyc == busy_start_at + 1) checkOutput({tag, "_busy_ignore"}, 32'(busy), 1);
      start = (cyc == busy_start_at);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_latency));
    checkOutput({tag, "_err"},     32'(err_count), 32'(exp_err));
    checkOutput({tag, "_pass"},    32'(pass), 32'(exp_err == 0));
    checkOutput({tag, "_fail_a"},  32'(fail_a), exp_first < 0 ? 0 : 32'(exp_first / 16));
    checkOutput({tag, "_fail_b"},  32'(fail_b), exp_first < 0 ? 0 : 32'(exp_first % 16));
    checkOutput({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    #(200000 * 10);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int v = 0; v < 256; v++) flip_tbl[v] = 4'd0;
    repeat (3) @(negedge clk);
    checkResetState("por");

    // Start issued together with reset release: first rising edge must accept it.
    rst_n = 1'b1;
    runSweep("clean", -1, -1);

    for (int v = 0; v < 256; v++) flip_tbl[v] = (v[4] && v[0]) ? 4'b0001 : 4'b0000;
    runSweep("stuck0", -1, -1);
    runSweep("stuck0_busy", 100, -1);

    for (int r = 0; r < 4; r++) begin
      int dens = (r == 0) ? 0 : int'($urandom_range(1, 30));
      for (int v = 0; v < 256; v++)
        flip_tbl[v] = ($urandom_range(0, 99) < dens) ? 4'($urandom_range(1, 15)) : 4'd0;
      runSweep($sformatf("rand%0d", r), -1, -1);
    end

    for (int v = 0; v < 256; v++) flip_tbl[v] = 4'd0;
    runSweep("rst_mid", -1, 8'h80 * PER_VEC + 1);
    repeat (2) @(negedge clk);
    checkResetState("rst_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("no_auto_restart_busy", 32'(busy), 0);
    checkOutput("no_auto_restart_done", 32'(done), 0);
    runSweep("after_rst", -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
